// File: rtl/mul16_pkg.sv
// mul16_pkg: shared types and constants for the sequential 16-bit multiplier
//   state_t : FSM encoding (IDLE, CALC, DONE)
//   WIDTH   : operand/product width
//   CNT_W   : step counter width
//   STEPS   : shift-add steps per operation
package mul16_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam int STEPS = 16;
endpackage

// File: rtl/multiplier_16bit_seq.sv
// multiplier_16bit_seq: unsigned shift-add multiplier, one step per cycle, fixed latency
//   clk, rst_n            : clock, asynchronous active-low reset
//   start                 : request, sampled in IDLE only
//   multiplicand/multiplier : operands A/B, captured on the accepting edge
//   product               : low WIDTH bits of A*B
//   overflow              : upper WIDTH bits of A*B nonzero
//   zero_operand          : A==0 or B==0
//   busy, done            : busy in CALC/DONE, done one-cycle pulse with valid results
module multiplier_16bit_seq
  import mul16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] product,
  output logic             overflow,
  output logic             zero_operand,
  output logic             busy,
  output logic             done
);
  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] w_add;
  logic [2*WIDTH-1:0] w_acc_nxt;
  // A stays unshifted; the counter positions it, B shifts to expose the next bit
  assign w_add     = r_b[0] ? ({{WIDTH{1'b0}}, r_a} << r_cnt) : '0;
  assign w_acc_nxt = r_acc + w_add;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      product      <= '0;
      overflow     <= 1'b0;
      zero_operand <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_a     <= multiplicand;
          r_b     <= multiplier;
          r_acc   <= '0;
          r_cnt   <= '0;
          busy    <= 1'b1;
          r_state <= CALC;
        end
        CALC: begin
          r_acc <= w_acc_nxt;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
          // last step: results taken from the post-add value so no extra cycle is spent
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            product      <= w_acc_nxt[WIDTH-1:0];
            overflow     <= |w_acc_nxt[2*WIDTH-1:WIDTH];
            // an unsigned product is zero exactly when an operand is zero
            zero_operand <= (w_acc_nxt == '0);
            done         <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiplier_16bit_seq.sv
// tb_multiplier_16bit_seq: directed self-checking bench for multiplier_16bit_seq
module tb_multiplier_16bit_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] multiplicand = '0;
  logic [15:0] multiplier = '0;
  logic [15:0] product;
  logic        overflow;
  logic        zero_operand;
  logic        busy;
  logic        done;
  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  multiplier_16bit_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .product(product), .overflow(overflow), .zero_operand(zero_operand),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // the posedge after start is driven is the accepting edge (edge 0); operands are scrambled afterwards
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = ~a;
    multiplier   = ~b;
  endtask

  // done must first be seen high after edge 16 (i.e. present at edge 17) and last one cycle
  task automatic wait_done(input string tag, input logic [15:0] p, input logic ov, input logic z,
                           input bit inject);
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk);
      #1;
      chk({tag, "_early_done"}, 32'(done), 32'd0);
      if (k == 1) chk({tag, "_busy_calc"}, 32'(busy), 32'd1);
      if (inject && k == 5) begin
        start = 1'b1; multiplicand = 16'd2; multiplier = 16'd2;
      end
      if (inject && k == 14) start = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_product"}, 32'(product), 32'(p));
    chk({tag, "_overflow"}, 32'(overflow), 32'(ov));
    chk({tag, "_zero"}, 32'(zero_operand), 32'(z));
    chk({tag, "_busy_done"}, 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, 32'(product), 32'(p));
  endtask

  initial begin
    int t0;
    bit seen;
    #3;
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_flags", {28'd0, overflow, zero_operand, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    launch(16'd3, 16'd5);
    wait_done("small", 16'd15, 1'b0, 1'b0, 1'b0);

    launch(16'd0, 16'd1234);
    wait_done("zero", 16'd0, 1'b0, 1'b1, 1'b0);

    launch(16'd7, 16'd9);
    wait_done("busy_start", 16'd63, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) chk("no_queued_op", {30'd0, busy, done}, 32'd0);
    end
    chk("busy_start_hold", 32'(product), 32'd63);

    launch(16'd300, 16'd300);
    wait_done("ovf", 16'h5F90, 1'b1, 1'b0, 1'b0);

    launch(16'hFFFF, 16'hFFFF);
    wait_done("max", 16'h0001, 1'b1, 1'b0, 1'b0);

    launch(16'd100, 16'd100);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_product", 32'(product), 32'd0);
    chk("midrst_flags", {28'd0, overflow, zero_operand, busy, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    launch(16'd100, 16'd100);
    wait_done("after_rst", 16'd10000, 1'b0, 1'b0, 1'b0);

    // start held high: consecutive done pulses 18 cycles apart
    @(negedge clk);
    multiplicand = 16'd3; multiplier = 16'd5; start = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("b2b_first", 32'(seen), 32'd1);
    t0 = cyc;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("b2b_second", 32'(seen), 32'd1);
    chk("b2b_period", 32'(cyc - t0), 32'd18);
    chk("b2b_product", 32'(product), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/multiplier_16bit_seq.md
MULTIPLIER_16BIT_SEQ -- requirements
Module: multiplier_16bit_seq

Interface
REQ-001 Parameter: WIDTH, default 16, operand and product width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request; sampled only in IDLE.
REQ-005 multiplicand  in  16  unsigned operand A; captured on the accepting edge.
REQ-006 multiplier  in  16  unsigned operand B; captured on the accepting edge.
REQ-007 product  out  16  low 16 bits of A*B.
REQ-008 overflow  out  1  high when A*B > 0xFFFF, i.e. the upper 16 bits are nonzero.
REQ-009 zero_operand  out  1  high when A==0 or B==0.
REQ-010 busy  out  1  high in CALC and DONE.
REQ-011 done  out  1  one-cycle pulse; results are valid from that cycle on.

Function
REQ-012 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-013 IDLE with start=1 SHALL capture A and B, clear the 32-bit accumulator and the 5-bit counter, and go to CALC.
REQ-014 CALC SHALL perform one shift-add step per cycle:
- if B[0]=1, add A (shifted to the current position) into the accumulator;
- shift B right by 1;
- increment the counter.
REQ-015 CALC SHALL go to DONE after exactly 16 steps, with no early exit for zero operands; the latency is fixed.
REQ-016 On the CALC->DONE edge, product, overflow and zero_operand SHALL be registered from the accumulator and the captured operands.
REQ-017 done SHALL be high only in DONE, exactly one cycle, 17 edges after the accepting edge (the accepting edge is edge 0).
REQ-018 DONE SHALL return to IDLE unconditionally.
REQ-019 start in CALC or DONE SHALL be ignored, with no queuing.
REQ-020 Operand changes after the accepting edge SHALL have no effect.
REQ-021 product, overflow and zero_operand SHALL hold their values until the next DONE.
REQ-022 start held high continuously SHALL launch back-to-back operations, one every 18 cycles.
REQ-023 All arithmetic SHALL be unsigned; the internal accumulator SHALL be 32 bits so that no intermediate result is lost.
REQ-024 For 0xFFFF*0xFFFF the accumulator SHALL reach 0xFFFE0001 with no wrap.
REQ-025 When zero_operand=1, the result SHALL be product=0 and overflow=0.

Reset
REQ-026 rst_n=0 SHALL immediately force:
- state to IDLE;
- product, overflow, zero_operand, busy, done, accumulator, counter and operand registers to 0.
REQ-027 Reset during CALC SHALL abort the operation with no done pulse.
REQ-028 After rst_n rises, the first start seen at a clock edge SHALL be accepted normally.
REQ-029 Reset release SHALL be synchronized externally; the block itself assumes only the asynchronous assert.

Structure
REQ-030 Shared package mul16_pkg SHALL contain:
- the state enum (IDLE, CALC, DONE);
- WIDTH=16;
- CNT_W=5;
- STEPS=16.
REQ-031 The block SHALL be a single module with no sub-module; the datapath (adder, shifter, counter) SHALL be inline.
REQ-032 All outputs SHALL be driven directly from flops, with no combinational path from inputs to outputs.

Verification
REQ-033 Small operands: A=3, B=5, start pulse -> done 17 edges later; product=15, overflow=0, zero_operand=0.
REQ-034 Overflow: A=300, B=300 -> product=0x5F90, overflow=1 (A*B=0x15F90).
REQ-035 Maximum operands: A=0xFFFF, B=0xFFFF -> product=0x0001, overflow=1; zero_operand=0.
REQ-036 Zero operand: A=0, B=1234 -> product=0, overflow=0, zero_operand=1; latency is still 17 edges.
REQ-037 Start during busy: after A=7, B=9 is accepted, assert start with A=2, B=2 mid-CALC -> product=63 and only one done pulse; the next result appears only after a new start in IDLE.
REQ-038 Reset mid-operation: start A=100, B=100, assert rst_n=0 at step 8 -> all outputs 0 immediately, no done; a subsequent start of A=100, B=100 -> product=10000, overflow=0.
